inv_sub_bytes_iter: RTL and testbench
=====================================

INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  in_data is presented.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port in_data  input  128  AES state; byte 0 = in_data[127:120], byte 15 = in_data[7:0].
REQ-007 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-008 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-009 SHALL have port out_data  output  128  inverse-substituted state, same byte order as in_data.
REQ-010 SHALL have port busy  output  1  a substitution is in progress (state RUN).

Function
REQ-011 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE.
REQ-013 SHALL drive out_valid = 1 only in DONE.
REQ-014 SHALL drive busy = 1 only in RUN.
REQ-015 SHALL, in IDLE with in_valid = 1, capture in_data into an internal 128-bit register, clear the byte counter and enter RUN.
REQ-016 SHALL, each cycle in RUN, replace LANES consecutive bytes, starting at byte index = counter, with their AES inverse S-box values (FIPS-197 InvSubBytes), then advance the counter by LANES.
REQ-017 SHALL enter DONE on the cycle the last group (bytes 16-LANES..15) is written.
- RUN therefore lasts 16/LANES cycles.
- out_valid rises 16/LANES+1 cycles after the in_valid and in_ready handshake edge.
- With the default LANES=4, that is 5 cycles.
REQ-018 SHALL drive out_data from the internal register at all times.
- out_data is stable and unchanged while out_valid = 1 and out_ready = 0.
REQ-019 SHALL, in DONE with out_ready = 1, return to IDLE on that edge.
- in_ready therefore rises the following cycle.
- No accept coincides with the output handshake.
REQ-020 SHALL ignore in_valid and in_data outside IDLE.
- The captured state is not altered by input changes during RUN or DONE.
REQ-021 SHALL process bytes in ascending index order.
- Counter width is 5 bits, wide enough to hold 16 without wrap.
- Counter values at or above 16 are unreachable.
REQ-022 SHALL hold in DONE indefinitely while out_ready = 0 (unbounded backpressure).
REQ-023 SHALL keep out_data combinationally independent of in_data, out_ready and in_valid (registered output).

Reset
REQ-024 SHALL, while rst = 1, asynchronously force:
- state to IDLE;
- counter to 0;
- internal state register and out_data to 128'h0;
- out_valid = 0 and busy = 0;
- in_ready = 1 once state is IDLE.
REQ-025 SHALL, on rst asserted mid-RUN or in DONE, discard the partial or completed result; no output handshake follows.
REQ-026 SHALL accept a new state on the first rising clk edge after rst deasserts, if in_valid = 1.

Structure
REQ-027 SHALL place the following in the shared AES package:
- the 256-entry inverse S-box constant table;
- the state-encoding type (IDLE/RUN/DONE);
- the constants AES_STATE_W = 128 and AES_BYTE_W = 8.
REQ-028 SHALL instantiate LANES copies of one sub-module, inv_sbox (8-bit in, 8-bit combinational out).
- inv_sbox is the inverse counterpart of the forward byte S-box used by the encrypt datapath.
REQ-029 SHALL elaborate-time error on a LANES value not in {1,2,4,8,16}.

Verification
REQ-030 SHALL cover: LANES=4, in_data = 128'h63636363636363636363636363636363 -> out_data = 128'h0; out_valid exactly 5 cycles after the accept edge.
REQ-031 SHALL cover: in_data = 128'h637c777bf26b6fc53001672bfed7ab76 -> out_data = 128'h000102030405060708090a0b0c0d0e0f.
REQ-032 SHALL cover: in_data = 128'h0 -> out_data = 128'h52525252525252525252525252525252; then in_data all bytes 0x16 -> all bytes 0xFF.
REQ-033 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE, in_valid toggling with new data.
- out_data stays stable, in_ready stays 0.
- Release out_ready -> in_ready = 1 next cycle.
REQ-034 SHALL cover rst asserted on the 2nd RUN cycle: out_valid, busy and out_data = 0 immediately (asynchronous), no output handshake follows, and the next accepted state yields a correct result.
REQ-035 SHALL cover LANES=1 and LANES=16 with the REQ-031 vector.
- out_valid appears after 17 and 2 cycles respectively.
- Bench compares against a reference inverse S-box model with 1000 random states.

Source files
------------

// File: rtl/inv_sub_bytes_iter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inv_sub_bytes_iter_pkg : shared AES constants, state type, inv S-box |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
package inv_sub_bytes_iter_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_BYTES   = AES_STATE_W / AES_BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Index 0 is the leftmost entry of the concatenation.
  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage
`default_nettype wire

// File: rtl/inv_sub_bytes_iter_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inv_sbox : combinational single-byte AES inverse S-box lookup       |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module inv_sbox
  import inv_sub_bytes_iter_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  assign out_byte = INV_SBOX[in_byte];

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inv_sub_bytes_iter : iterative AES InvSubBytes, LANES bytes/cycle   |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] C_STEP = 5'(LANES);
  localparam logic [4:0] C_LAST = 5'(AES_BYTES - LANES);

  aes_state_e                         fsm_q, fsm_d;
  logic [4:0]                         cnt_q, cnt_d;
  // Byte 0 sits in the most significant position, matching the port order.
  logic [0:AES_BYTES-1][AES_BYTE_W-1:0] state_q, state_d;
  logic                               in_ready_q, in_ready_d;
  logic                               out_valid_q, out_valid_d;
  logic                               busy_q, busy_d;
  logic [LANES-1:0][AES_BYTE_W-1:0]   sb_out;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [3:0] idx;
    assign idx = cnt_q[3:0] + 4'(g);
    inv_sbox u_inv_sbox (
      .in_byte  (state_q[idx]),
      .out_byte (sb_out[g])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          cnt_d   = 5'd0;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < LANES; i++) begin
          state_d[cnt_q[3:0] + 4'(i)] = sb_out[i];
        end
        cnt_d = cnt_q + C_STEP;
        if (cnt_q == C_LAST) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
    busy_d      = (fsm_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= 5'd0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inv_sub_bytes_iter : scoreboard bench for LANES = 4, 1 and 16    |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_inv_sub_bytes_iter;

  localparam logic [127:0] C_V31   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] C_V31_R = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] in_data   [3];
  logic [127:0] out_data  [3];

  logic [127:0] sb0 [$];
  logic [127:0] sb1 [$];
  logic [127:0] sb2 [$];
  logic [7:0]   ref_inv [256];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  inv_sub_bytes_iter #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
  inv_sub_bytes_iter #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Reference table derived from GF(2^8) inversion and the forward affine map.
  task automatic build_ref();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_inv[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic push_exp(input int d, input logic [127:0] v);
    case (d)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic pop_check(input int d, input logic [127:0] got);
    logic [127:0] e;
    int sz;
    sz = (d == 0) ? sb0.size() : (d == 1) ? sb1.size() : sb2.size();
    if (sz == 0) begin
      check($sformatf("unexpected_out%0d", d), got, 128'hx);
    end else begin
      case (d)
        0:       e = sb0.pop_front();
        1:       e = sb1.pop_front();
        default: e = sb2.pop_front();
      endcase
      check($sformatf("out_data%0d", d), got, e);
    end
  endtask

  always @(negedge clk) if (!rst && out_valid[0] && out_ready[0]) pop_check(0, out_data[0]);
  always @(negedge clk) if (!rst && out_valid[1] && out_ready[1]) pop_check(1, out_data[1]);
  always @(negedge clk) if (!rst && out_valid[2] && out_ready[2]) pop_check(2, out_data[2]);

  // Counts cycles from the accept edge to the first cycle showing out_valid.
  task automatic send(input int d, input logic [127:0] data, input int lat_exp);
    int n;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      check("accept_timeout", 128'(in_ready[d]), 128'd1);
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    push_exp(d, ref_state(data));
    #1;
    in_valid[d] = 1'b0;
    in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[d] && n < 40);
    check($sformatf("latency%0d", d), 128'(n), 128'(lat_exp));
  endtask

  initial begin
    logic [127:0] hold;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    rst = 1'b1;
    build_ref();
    check("ref_model_v31", ref_state(C_V31), C_V31_R);
    repeat (2) @(negedge clk);
    check("rst_in_ready",  128'(in_ready[0]),  128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_busy",      128'(busy[0]),      128'd0);
    check("rst_out_data",  out_data[0],        128'h0);
    rst = 1'b0;

    send(0, {16{8'h63}}, 5);
    send(0, C_V31, 5);
    send(0, 128'h0, 5);
    send(0, {16{8'h16}}, 5);

    // Output stall: DONE must hold while new inputs churn.
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    send(0, 128'h0123456789abcdeffedcba9876543210, 5);
    hold = out_data[0];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid[0] = ~in_valid[0];
      in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_data_stable", out_data[0], hold);
      check("bp_in_ready",    128'(in_ready[0]),  128'd0);
      check("bp_out_valid",   128'(out_valid[0]), 128'd1);
    end
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 128'(in_ready[0]), 128'd1);

    // Reset during the second RUN cycle.
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data[0]  = C_V31;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #3;
    check("mid_run_busy", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid[0]), 128'd0);
    check("arst_busy",      128'(busy[0]),      128'd0);
    check("arst_out_data",  out_data[0],        128'h0);
    check("arst_in_ready",  128'(in_ready[0]),  128'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_out", 128'(out_valid[0]), 128'd0);
    end
    send(0, C_V31, 5);

    send(1, C_V31, 17);
    send(2, C_V31, 2);

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        send(d, {$urandom, $urandom, $urandom, $urandom}, (d == 0) ? 5 : (d == 1) ? 17 : 2);
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb0.size() + sb1.size() + sb2.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
